// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [6:0] SLAVE_ADDRESS = 7'h57;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: a tick every DIV clocks, plus the 2-bit phase within the bit period.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int unsigned DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt <= '0;
            phase   <= Q0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= phase + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] slave_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  logic       sda
);

    state_t     state;
    state_t     state_n;
    logic       tick;
    logic [1:0] phase;
    logic       gen_en;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] wdata_q;
    logic       rw_q;
    logic       sda_low;
    logic       sda_in;
    logic       scl_n;
    logic       sda_low_n;
    logic       accept;
    logic       period_end;
    logic       sample;

    assign sda        = sda_low ? 1'b0 : 1'bz;
    assign sda_in     = sda;
    assign gen_en     = (state != IDLE);
    assign accept     = (state == IDLE) && req && !busy;
    assign period_end = tick && (phase == Q3);
    assign sample     = tick && (phase == Q1);

    i2c_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (gen_en),
        .tick   (tick),
        .phase  (phase)
    );

    // Pin levels are derived from the current state/phase and registered, so they
    // trail the phase counter by one clock; sampling at the Q1 tick still lands while scl is high.
    always_comb begin
        state_n   = state;
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = START;
            end
            START: begin
                scl_n     = (phase != Q3);
                sda_low_n = (phase inside {Q2, Q3});
                if (period_end) state_n = ADDR;
            end
            ADDR: begin
                scl_n     = (phase inside {Q1, Q2});
                sda_low_n = !tx_sh[7];
                if (period_end && bit_cnt == 3'd7) state_n = ACK1;
            end
            ACK1: begin
                scl_n = (phase inside {Q1, Q2});
                if (period_end) state_n = ack_err ? STOP : DATA;
            end
            DATA: begin
                scl_n     = (phase inside {Q1, Q2});
                sda_low_n = !rw_q && !tx_sh[7];
                if (period_end && bit_cnt == 3'd7) state_n = ACK2;
            end
            ACK2: begin
                scl_n = (phase inside {Q1, Q2});
                if (period_end) state_n = STOP;
            end
            STOP: begin
                scl_n     = (phase != Q0);
                sda_low_n = (phase != Q3);
                if (period_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            scl     <= 1'b1;
            sda_low <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
        end else begin
            state   <= state_n;
            scl     <= scl_n;
            sda_low <= sda_low_n;
            done    <= 1'b0;

            if (accept) begin
                tx_sh   <= {slave_addr, rw};
                wdata_q <= wdata;
                rw_q    <= rw;
                ack_err <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end

            // Back in IDLE with busy still set: one cycle to raise done, one to drop both,
            // which keeps req from being accepted during the done cycle.
            if (state == IDLE && busy) begin
                done <= !done;
                busy <= !done;
            end

            if (sample) begin
                case (state)
                    ACK1:    if (sda_in) ack_err <= 1'b1;
                    DATA:    if (rw_q) rx_sh <= {rx_sh[6:0], sda_in};
                    ACK2:    if (!rw_q && sda_in) ack_err <= 1'b1;
                    default: ;
                endcase
            end

            if (period_end) begin
                case (state)
                    ADDR, DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                    ACK1:    tx_sh <= wdata_q;
                    STOP:    if (rw_q && !ack_err) rdata <= rx_sh;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl with a behavioural I2C slave (address 7'h57) on an open-drain SDA.
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int unsigned DIV = 4;
    localparam int FULL_LAT = 80 * DIV + 1;
    localparam int NACK_LAT = 44 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] slave_addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda_w;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] model_rdata = '0;

    // slave model state
    logic       slave_low = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       s_active = 1'b0;
    int         s_stage = 4;
    int         s_bits = 0;
    int         s_rises = 0;
    int         s_starts = 0;
    int         s_stops = 0;
    logic [7:0] s_sh = '0;
    logic [7:0] s_tx = '0;
    logic [7:0] s_stored = 8'hCD;
    logic [7:0] s_addr_byte = '0;
    logic [7:0] s_captured = '0;
    logic       s_cap_valid = 1'b0;
    logic       s_read = 1'b0;
    logic       s_master_ack = 1'b0;

    pullup (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rw         (rw),
        .slave_addr (slave_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .scl        (scl),
        .sda        (sda_w)
    );

    // Slave: START/STOP are SDA edges with SCL high; bits sampled on SCL rise, SDA driven after SCL fall.
    always @(scl or sda_w) begin
        if (scl === 1'b1 && prev_scl === 1'b1 && sda_w !== prev_sda) begin
            if (sda_w === 1'b0) begin
                s_starts++;
                s_active = 1'b1;
                s_stage = 0;
                s_bits = 0;
                s_rises = 0;
                s_sh = '0;
                s_tx = s_stored;
                s_cap_valid = 1'b0;
                s_master_ack = 1'b0;
                slave_low = 1'b0;
            end else if (s_active) begin
                s_stops++;
                s_active = 1'b0;
            end
        end else if (scl === 1'b1 && prev_scl !== 1'b1 && s_active) begin
            s_rises++;
            case (s_stage)
                0: begin s_sh = {s_sh[6:0], sda_w}; s_bits++; end
                2: begin if (!s_read) s_sh = {s_sh[6:0], sda_w}; s_bits++; end
                3: if (s_read) s_master_ack = sda_w;
                default: ;
            endcase
        end else if (scl === 1'b0 && prev_scl === 1'b1 && s_active) begin
            case (s_stage)
                0: if (s_bits == 8) begin
                    s_addr_byte = s_sh;
                    if (s_sh[7:1] == SLAVE_ADDRESS) begin
                        s_read = s_sh[0];
                        slave_low = 1'b1;
                        s_stage = 1;
                    end else begin
                        s_stage = 4;
                    end
                end
                1: begin
                    s_stage = 2;
                    s_bits = 0;
                    slave_low = s_read ? !s_tx[7] : 1'b0;
                end
                2: if (s_bits == 8) begin
                    if (s_read) begin
                        slave_low = 1'b0;
                    end else begin
                        s_captured = s_sh;
                        s_cap_valid = 1'b1;
                        slave_low = 1'b1;
                    end
                    s_stage = 3;
                end else if (s_read) begin
                    slave_low = !s_tx[7 - s_bits];
                end
                3: begin slave_low = 1'b0; s_stage = 4; end
                default: ;
            endcase
        end
        prev_scl = scl;
        prev_sda = sda_w;
    end

    // Transaction-level expectations: 20 bit periods when addressed, 11 (START+ADDR+ACK1+STOP) on NACK.
    function automatic void ref_model(input logic [6:0] a, input logic r, input logic [7:0] stored,
                                      input logic [7:0] prev_rd, output logic e_err,
                                      output logic [7:0] e_rd, output int e_lat, output int e_rises);
        logic hit;
        int periods;
        hit = (a == SLAVE_ADDRESS);
        periods = hit ? 20 : 11;
        e_err = !hit;
        e_rd = (hit && r) ? stored : prev_rd;
        e_lat = periods * 4 * int'(DIV) + 1;
        e_rises = periods - 1;
    endfunction

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d, output int lat,
                           output int starts, output int stops);
        int st0, sp0;
        repeat (2) @(posedge clk);
        #1;
        st0 = s_starts;
        sp0 = s_stops;
        req = 1'b1;
        slave_addr = a;
        rw = r;
        wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        slave_addr = 7'($urandom);
        wdata = 8'($urandom);
        rw = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        starts = s_starts - st0;
        stops = s_stops - sp0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (scl !== 1'b1) begin n_err++; $display("FAIL reset_scl: got %b want 1", scl); end
        n_cmp++; if (sda_w !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1 (released)", sda_w); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (ack_err !== 1'b0) begin n_err++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        model_rdata = 8'h00;
    endtask

    task automatic test_write;
        int lat, st, sp;
        s_stored = 8'hCD;
        run_txn(7'h57, 1'b0, 8'hA5, lat, st, sp);
        n_cmp++; if (lat != FULL_LAT) begin n_err++; $display("FAIL write_latency: got %0d want %0d", lat, FULL_LAT); end
        n_cmp++; if (ack_err !== 1'b0) begin n_err++; $display("FAIL write_ack_err: got %b want 0", ack_err); end
        n_cmp++; if (s_addr_byte !== 8'hAE) begin n_err++; $display("FAIL write_addr_bits: got %h want ae", s_addr_byte); end
        n_cmp++; if (!s_cap_valid || s_captured !== 8'hA5) begin n_err++; $display("FAIL write_slave_byte: got %h valid %b want a5", s_captured, s_cap_valid); end
        n_cmp++; if (s_rises != 19) begin n_err++; $display("FAIL write_scl_pulses: got %0d want 19", s_rises); end
        n_cmp++; if (st != 1 || sp != 1) begin n_err++; $display("FAIL write_start_stop: got %0d/%0d want 1/1", st, sp); end
        n_cmp++; if (rdata !== model_rdata) begin n_err++; $display("FAIL write_rdata_kept: got %h want %h", rdata, model_rdata); end
        @(posedge clk);
        #1;
        n_cmp++; if (scl !== 1'b1 || sda_w !== 1'b1) begin n_err++; $display("FAIL write_bus_idle: got scl %b sda %b want 1 1", scl, sda_w); end
    endtask

    task automatic test_read;
        int lat, st, sp;
        s_stored = 8'hCD;
        run_txn(7'h57, 1'b1, 8'h00, lat, st, sp);
        model_rdata = 8'hCD;
        n_cmp++; if (lat != FULL_LAT) begin n_err++; $display("FAIL read_latency: got %0d want %0d", lat, FULL_LAT); end
        n_cmp++; if (rdata !== 8'hCD) begin n_err++; $display("FAIL read_rdata: got %h want cd", rdata); end
        n_cmp++; if (ack_err !== 1'b0) begin n_err++; $display("FAIL read_ack_err: got %b want 0", ack_err); end
        n_cmp++; if (s_master_ack !== 1'b1) begin n_err++; $display("FAIL read_master_nack: got %b want 1", s_master_ack); end
        n_cmp++; if (s_addr_byte !== 8'hAF) begin n_err++; $display("FAIL read_addr_bits: got %h want af", s_addr_byte); end
    endtask

    task automatic test_addr_nack;
        int lat, st, sp;
        run_txn(7'h12, 1'b0, 8'h3C, lat, st, sp);
        n_cmp++; if (lat != NACK_LAT) begin n_err++; $display("FAIL nack_latency: got %0d want %0d", lat, NACK_LAT); end
        n_cmp++; if (ack_err !== 1'b1) begin n_err++; $display("FAIL nack_ack_err: got %b want 1", ack_err); end
        n_cmp++; if (s_rises != 10) begin n_err++; $display("FAIL nack_scl_pulses: got %0d want 10", s_rises); end
        n_cmp++; if (st != 1 || sp != 1) begin n_err++; $display("FAIL nack_start_stop: got %0d/%0d want 1/1", st, sp); end
        n_cmp++; if (rdata !== model_rdata) begin n_err++; $display("FAIL nack_rdata_kept: got %h want %h", rdata, model_rdata); end
    endtask

    task automatic test_back_to_back;
        int lat;
        s_stored = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1;
        slave_addr = 7'h57;
        rw = 1'b0;
        wdata = 8'h96;
        @(posedge clk);
        #1;
        rw = 1'b1;
        wdata = 8'h11;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != FULL_LAT) begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, FULL_LAT); end
        n_cmp++; if (s_captured !== 8'h96) begin n_err++; $display("FAIL b2b_first_byte: got %h want 96", s_captured); end
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got busy %b want 1", busy); end
        req = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin @(posedge clk); #1; lat++; end
        model_rdata = 8'h3C;
        n_cmp++; if (lat != FULL_LAT) begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, FULL_LAT); end
        n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL b2b_second_rdata: got %h want 3c", rdata); end
    endtask

    task automatic test_reset_mid;
        int lat, st, sp;
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1;
        slave_addr = 7'h57;
        rw = 1'b0;
        wdata = 8'h5A;
        @(posedge clk);
        #1;
        req = 1'b0;
        // START is 4*DIV clocks, each address bit 4*DIV; stop half-way through address bit 3
        repeat (4 * DIV + 3 * 4 * DIV + 2 * DIV - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_rdata = 8'h00;
        n_cmp++; if (scl !== 1'b1) begin n_err++; $display("FAIL midrst_scl: got %b want 1", scl); end
        n_cmp++; if (sda_w !== 1'b1) begin n_err++; $display("FAIL midrst_sda: got %b want 1 (released)", sda_w); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_busy_done: got %b%b want 00", busy, done); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL midrst_rdata: got %h want 00", rdata); end
        repeat (3) @(posedge clk);
        run_txn(7'h57, 1'b0, 8'h5A, lat, st, sp);
        n_cmp++; if (lat != FULL_LAT) begin n_err++; $display("FAIL midrst_retry_latency: got %0d want %0d", lat, FULL_LAT); end
        n_cmp++; if (ack_err !== 1'b0) begin n_err++; $display("FAIL midrst_retry_ack_err: got %b want 0", ack_err); end
        n_cmp++; if (s_captured !== 8'h5A) begin n_err++; $display("FAIL midrst_retry_byte: got %h want 5a", s_captured); end
    endtask

    task automatic test_random;
        logic [6:0] a;
        logic r, e_err;
        logic [7:0] d, e_rd;
        int lat, e_lat, e_rises, st, sp;
        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 1) == 1) ? SLAVE_ADDRESS : 7'($urandom);
            r = 1'($urandom);
            d = 8'($urandom);
            s_stored = 8'($urandom);
            ref_model(a, r, s_stored, model_rdata, e_err, e_rd, e_lat, e_rises);
            run_txn(a, r, d, lat, st, sp);
            model_rdata = e_rd;
            n_cmp++; if (lat != e_lat) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, e_lat); end
            n_cmp++; if (ack_err !== e_err) begin n_err++; $display("FAIL rand%0d_ack_err: got %b want %b", i, ack_err, e_err); end
            n_cmp++; if (rdata !== e_rd) begin n_err++; $display("FAIL rand%0d_rdata: got %h want %h", i, rdata, e_rd); end
            n_cmp++; if (s_rises != e_rises) begin n_err++; $display("FAIL rand%0d_scl_pulses: got %0d want %0d", i, s_rises, e_rises); end
            n_cmp++; if (s_addr_byte !== {a, r}) begin n_err++; $display("FAIL rand%0d_addr_bits: got %h want %h", i, s_addr_byte, {a, r}); end
            if (!e_err && !r) begin
                n_cmp++; if (!s_cap_valid || s_captured !== d) begin n_err++; $display("FAIL rand%0d_slave_byte: got %h want %h", i, s_captured, d); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
